// File: rtl/rs_alu_pkg.sv
// Shared constants for the ALU reservation station: datapath width and the ALU opcode encoding.
// The age-based select option is enabled by defining RS_AGE_SELECT_EN.
package rs_alu_pkg;

    localparam int REG_WIDTH = 32;
    localparam int OP_WIDTH  = 4;

    // Opcode encoding shared with the ALU; 0 is never dispatched.
    typedef enum logic [OP_WIDTH-1:0] {
        OP_NONE = 4'd0,
        OP_AND  = 4'd1,
        OP_OR   = 4'd2,
        OP_XOR  = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10,
        OP_BEQ  = 4'd11,
        OP_BNE  = 4'd12,
        OP_BLT  = 4'd13,
        OP_BGE  = 4'd14,
        OP_JALR = 4'd15
    } alu_op_e;

endpackage

// File: rtl/rs_select.sv
// Issue arbiter for the ALU reservation station: one-hot grant over the ready vector.
// With RS_AGE_SELECT_EN the oldest ready entry wins (ties to lowest index); otherwise lowest index wins.
module rs_select #(
    parameter int N  = 8
`ifdef RS_AGE_SELECT_EN
    ,
    parameter int AW = 3
`endif
) (
    input  logic [N-1:0]    ready,
`ifdef RS_AGE_SELECT_EN
    input  logic [N*AW-1:0] ages,
`endif
    output logic [N-1:0]    grant,
    output logic            found
);

`ifdef RS_AGE_SELECT_EN
    logic [AW-1:0] best_s;

    // Oldest-first arbitration; strict compare keeps ties on the lowest index.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        best_s = '0;
        for (int i = 0; i < N; i++) begin
            if (ready[i] && (!found || (ages[i*AW +: AW] > best_s))) begin
                grant    = '0;
                grant[i] = 1'b1;
                found    = 1'b1;
                best_s   = ages[i*AW +: AW];
            end else begin
                best_s = best_s;
            end
        end
    end
`else
    // Fixed-priority arbitration, lowest index first.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ready[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end else begin
                found = found;
            end
        end
    end
`endif

endmodule

// File: rtl/rs_alu.sv
// Reservation station in front of the ALU: buffers dispatched ops, snoops ALU/LSB result buses,
// and issues one ready op per cycle. Define RS_AGE_SELECT_EN for oldest-first selection.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int RS_WIDTH  = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [OP_WIDTH-1:0]  issue_opcode,
    input  logic [REG_WIDTH-1:0] issue_vj,
    input  logic [REG_WIDTH-1:0] issue_vk,
    input  logic                 issue_rj,
    input  logic                 issue_rk,
    input  logic [ROB_WIDTH-1:0] issue_qj,
    input  logic [ROB_WIDTH-1:0] issue_qk,
    input  logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 full,
    input  logic                 alu_done,
    input  logic [REG_WIDTH-1:0] alu_result,
    input  logic [ROB_WIDTH-1:0] alu_tag,
    input  logic                 lsb_done,
    input  logic [REG_WIDTH-1:0] lsb_result,
    input  logic [ROB_WIDTH-1:0] lsb_tag,
    output logic                 cal_signal,
    output logic [OP_WIDTH-1:0]  opcode,
    output logic [REG_WIDTH-1:0] lhs,
    output logic [REG_WIDTH-1:0] rhs,
    output logic [ROB_WIDTH-1:0] tag
);

    localparam int RS_SIZE = 2**RS_WIDTH;

    logic [RS_SIZE-1:0]   valid_r;
    logic [RS_SIZE-1:0]   rj_r;
    logic [RS_SIZE-1:0]   rk_r;
    logic [OP_WIDTH-1:0]  op_r   [RS_SIZE];
    logic [REG_WIDTH-1:0] vj_r   [RS_SIZE];
    logic [REG_WIDTH-1:0] vk_r   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_r   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_r   [RS_SIZE];
    logic [ROB_WIDTH-1:0] dest_r [RS_SIZE];

    logic                 full_s;
    logic [RS_SIZE-1:0]   ready_s;
    logic [RS_SIZE-1:0]   grant_s;
    logic                 found_s;
    logic [RS_WIDTH-1:0]  sel_idx_s;
    logic [RS_WIDTH-1:0]  free_idx_s;
    logic [REG_WIDTH:0]   wj_s [RS_SIZE];
    logic [REG_WIDTH:0]   wk_s [RS_SIZE];
    logic [REG_WIDTH:0]   bj_s;
    logic [REG_WIDTH:0]   bk_s;

`ifdef RS_AGE_SELECT_EN
    logic [RS_WIDTH-1:0]         age_r [RS_SIZE];
    logic [RS_SIZE*RS_WIDTH-1:0] ages_s;
`endif

    // Returns {ready, value} for one operand after snooping both result buses.
    function automatic logic [REG_WIDTH:0] snoop(
        input logic                 rdy,
        input logic [REG_WIDTH-1:0] val,
        input logic [ROB_WIDTH-1:0] q
    );
        if (rdy) begin
            snoop = {1'b1, val};
        end else if (alu_done && (q == alu_tag)) begin
            snoop = {1'b1, alu_result};
        end else if (lsb_done && (q == lsb_tag)) begin
            snoop = {1'b1, lsb_result};
        end else begin
            snoop = {1'b0, val};
        end
    endfunction

    // Occupancy, free-slot search, selected index and operand snooping.
    always_comb begin
        full_s     = &valid_r;
        ready_s    = valid_r & rj_r & rk_r;
        free_idx_s = '0;
        sel_idx_s  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_idx_s = RS_WIDTH'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (grant_s[i]) begin
                sel_idx_s = RS_WIDTH'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
            wj_s[i] = snoop(rj_r[i], vj_r[i], qj_r[i]);
            wk_s[i] = snoop(rk_r[i], vk_r[i], qk_r[i]);
        end
        bj_s = snoop(issue_rj, issue_vj, issue_qj);
        bk_s = snoop(issue_rk, issue_vk, issue_qk);
    end

    assign full = full_s;

`ifdef RS_AGE_SELECT_EN
    // Flatten ages for the arbiter.
    always_comb begin
        ages_s = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ages_s[i*RS_WIDTH +: RS_WIDTH] = age_r[i];
        end
    end

    rs_select #(.N(RS_SIZE), .AW(RS_WIDTH)) u_select (
        .ready (ready_s),
        .ages  (ages_s),
        .grant (grant_s),
        .found (found_s)
    );
`else
    rs_select #(.N(RS_SIZE)) u_select (
        .ready (ready_s),
        .grant (grant_s),
        .found (found_s)
    );
`endif

    // Entry storage, wakeup, issue write and registered ALU dispatch.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_r    <= '0;
            rj_r       <= '0;
            rk_r       <= '0;
            cal_signal <= 1'b0;
            opcode     <= '0;
            lhs        <= '0;
            rhs        <= '0;
            tag        <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_r[i]   <= '0;
                vj_r[i]   <= '0;
                vk_r[i]   <= '0;
                qj_r[i]   <= '0;
                qk_r[i]   <= '0;
                dest_r[i] <= '0;
`ifdef RS_AGE_SELECT_EN
                age_r[i]  <= '0;
`endif
            end
        end else if (rdy_in) begin
            if (flush) begin
                valid_r    <= '0;
                cal_signal <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (valid_r[i]) begin
                        {rj_r[i], vj_r[i]} <= wj_s[i];
                        {rk_r[i], vk_r[i]} <= wk_s[i];
`ifdef RS_AGE_SELECT_EN
                        if (age_r[i] != {RS_WIDTH{1'b1}}) begin
                            age_r[i] <= age_r[i] + RS_WIDTH'(1);
                        end
`endif
                    end
                end
                if (found_s) begin
                    valid_r[sel_idx_s] <= 1'b0;
                    cal_signal         <= 1'b1;
                    opcode             <= op_r[sel_idx_s];
                    lhs                <= vj_r[sel_idx_s];
                    rhs                <= vk_r[sel_idx_s];
                    tag                <= dest_r[sel_idx_s];
                end else begin
                    cal_signal <= 1'b0;
                end
                // Selected and free slots are always distinct, so both writes can coexist.
                if (issue_valid && !full_s) begin
                    valid_r[free_idx_s]                  <= 1'b1;
                    op_r[free_idx_s]                     <= issue_opcode;
                    {rj_r[free_idx_s], vj_r[free_idx_s]} <= bj_s;
                    {rk_r[free_idx_s], vk_r[free_idx_s]} <= bk_s;
                    qj_r[free_idx_s]                     <= issue_qj;
                    qk_r[free_idx_s]                     <= issue_qk;
                    dest_r[free_idx_s]                   <= issue_tag;
`ifdef RS_AGE_SELECT_EN
                    age_r[free_idx_s]                    <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against a slot-level behavioural model of the reservation station.
module tb_rs_alu;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        issue_valid;
    logic [3:0]  issue_opcode;
    logic [31:0] issue_vj, issue_vk;
    logic        issue_rj, issue_rk;
    logic [3:0]  issue_qj, issue_qk, issue_tag;
    logic        full;
    logic        alu_done, lsb_done;
    logic [31:0] alu_result, lsb_result;
    logic [3:0]  alu_tag, lsb_tag;
    logic        cal_signal;
    logic [3:0]  opcode;
    logic [31:0] lhs, rhs;
    logic [3:0]  tag;

    int n_cmp = 0;
    int n_bad = 0;

    rs_alu dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_rj(issue_rj), .issue_rk(issue_rk),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_tag(issue_tag), .full(full),
        .alu_done(alu_done), .alu_result(alu_result), .alu_tag(alu_tag),
        .lsb_done(lsb_done), .lsb_result(lsb_result), .lsb_tag(lsb_tag),
        .cal_signal(cal_signal), .opcode(opcode), .lhs(lhs), .rhs(rhs), .tag(tag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          valid;
        logic [3:0]  op;
        logic [31:0] vj, vk;
        bit          rj, rk;
        logic [3:0]  qj, qk, dest;
        int          age;
    } ent_t;

    ent_t        m [8];
    bit          m_cal;
    logic [3:0]  m_op, m_tag;
    logic [31:0] m_lhs, m_rhs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += m[i].valid ? 1 : 0;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = '{default: 0};
        m_cal = 0; m_op = 0; m_tag = 0; m_lhs = 0; m_rhs = 0;
    endtask

    task automatic snoop(inout bit r, inout logic [31:0] v, input logic [3:0] q);
        if (!r && alu_done && q == alu_tag) begin
            r = 1; v = alu_result;
        end else if (!r && lsb_done && q == lsb_tag) begin
            r = 1; v = lsb_result;
        end
    endtask

    // One clock edge of the reservation station, described slot by slot.
    task automatic model_step();
        int pick, slot;
        bit r;
        logic [31:0] v;
        if (rst_in) begin
            model_reset();
        end else if (rdy_in) begin
            if (flush) begin
                for (int i = 0; i < 8; i++) m[i].valid = 0;
                m_cal = 0;
            end else begin
                pick = -1;
                slot = -1;
                for (int i = 0; i < 8; i++) begin
                    if (slot < 0 && !m[i].valid) slot = i;
                    if (m[i].valid && m[i].rj && m[i].rk) begin
`ifdef RS_AGE_SELECT_EN
                        if (pick < 0 || m[i].age > m[pick].age) pick = i;
`else
                        if (pick < 0) pick = i;
`endif
                    end
                end
                for (int i = 0; i < 8; i++) begin
                    if (m[i].valid) begin
                        r = m[i].rj; v = m[i].vj; snoop(r, v, m[i].qj); m[i].rj = r; m[i].vj = v;
                        r = m[i].rk; v = m[i].vk; snoop(r, v, m[i].qk); m[i].rk = r; m[i].vk = v;
                        if (m[i].age < 7) m[i].age++;
                    end
                end
                if (pick >= 0) begin
                    m_cal = 1; m_op = m[pick].op; m_lhs = m[pick].vj;
                    m_rhs = m[pick].vk; m_tag = m[pick].dest;
                    m[pick].valid = 0;
                end else begin
                    m_cal = 0;
                end
                if (issue_valid && slot >= 0) begin
                    m[slot].valid = 1; m[slot].op = issue_opcode; m[slot].age = 0;
                    m[slot].qj = issue_qj; m[slot].qk = issue_qk; m[slot].dest = issue_tag;
                    r = issue_rj; v = issue_vj; snoop(r, v, issue_qj); m[slot].rj = r; m[slot].vj = v;
                    r = issue_rk; v = issue_vk; snoop(r, v, issue_qk); m[slot].rk = r; m[slot].vk = v;
                end
            end
        end
    endtask

    // Continuous comparison of every DUT output against the model.
    always @(negedge clk_in) begin
        chk("full", {31'd0, full}, {31'd0, (m_count() == 8)});
        chk("cal_signal", {31'd0, cal_signal}, {31'd0, m_cal});
        chk("opcode", {28'd0, opcode}, {28'd0, m_op});
        chk("lhs", lhs, m_lhs);
        chk("rhs", rhs, m_rhs);
        chk("tag", {28'd0, tag}, {28'd0, m_tag});
    end

    task automatic step();
        @(posedge clk_in);
        model_step();
        #1;
        issue_valid = 0; alu_done = 0; lsb_done = 0; flush = 0;
    endtask

    task automatic put(input logic [3:0] op, input logic [31:0] vj, input bit rj, input logic [3:0] qj,
                       input logic [31:0] vk, input bit rk, input logic [3:0] qk, input logic [3:0] t);
        issue_valid = 1; issue_opcode = op; issue_vj = vj; issue_rj = rj; issue_qj = qj;
        issue_vk = vk; issue_rk = rk; issue_qk = qk; issue_tag = t;
    endtask

    task automatic alu_bc(input logic [3:0] t, input logic [31:0] v);
        alu_done = 1; alu_tag = t; alu_result = v;
    endtask

    logic [3:0] first_tag, second_tag;

    initial begin
        model_reset();
        rst_in = 1; rdy_in = 1; flush = 0; issue_valid = 0; alu_done = 0; lsb_done = 0;
        issue_opcode = 0; issue_vj = 0; issue_vk = 0; issue_rj = 0; issue_rk = 0;
        issue_qj = 0; issue_qk = 0; issue_tag = 0;
        alu_result = 0; alu_tag = 0; lsb_result = 0; lsb_tag = 0;
        step(); step();
        rst_in = 0;
        chk("reset cal", {31'd0, cal_signal}, 32'd0);
        chk("reset full", {31'd0, full}, 32'd0);
        chk("reset lhs", lhs, 32'd0);

        // Ready ADD: written, then dispatched on the following edge.
        put(4'd4, 32'd5, 1, 4'd0, 32'd7, 1, 4'd0, 4'd3);
        step();
        chk("add early cal", {31'd0, cal_signal}, 32'd0);
        step();
        chk("add cal", {31'd0, cal_signal}, 32'd1);
        chk("add opcode", {28'd0, opcode}, 32'd4);
        chk("add lhs", lhs, 32'd5);
        chk("add rhs", rhs, 32'd7);
        chk("add tag", {28'd0, tag}, 32'd3);
        step();
        chk("add pulse width", {31'd0, cal_signal}, 32'd0);

        // SUB waits for tag 2 on the ALU bus.
        put(4'd5, 32'd0, 0, 4'd2, 32'd1, 1, 4'd0, 4'd4);
        step(); step();
        chk("sub waits", {31'd0, cal_signal}, 32'd0);
        alu_bc(4'd2, 32'd10);
        step(); step();
        chk("sub cal", {31'd0, cal_signal}, 32'd1);
        chk("sub lhs", lhs, 32'd10);
        chk("sub rhs", rhs, 32'd1);

        // Issue-cycle bypass from the LSB bus.
        put(4'd1, 32'd3, 1, 4'd0, 32'd0, 0, 4'd6, 4'd5);
        lsb_done = 1; lsb_tag = 4'd6; lsb_result = 32'hFFFF_FFFF;
        step(); step();
        chk("bypass cal", {31'd0, cal_signal}, 32'd1);
        chk("bypass rhs", rhs, 32'hFFFF_FFFF);
        step();

        // Fill all eight slots with pending ops; slot i waits on tag 8+i.
        for (int i = 0; i < 8; i++) begin
            put(4'd3, 32'd0, 0, 4'(8 + i), 32'(i), 1, 4'd0, 4'(i));
            step();
        end
        chk("fill full", {31'd0, full}, 32'd1);
        put(4'd4, 32'd1, 1, 4'd0, 32'd1, 1, 4'd0, 4'd9);
        step(); step();
        chk("ninth dropped", {31'd0, cal_signal}, 32'd0);
        alu_bc(4'd11, 32'd33);
        step(); step();
        chk("wake slot3 cal", {31'd0, cal_signal}, 32'd1);
        chk("wake slot3 tag", {28'd0, tag}, 32'd3);
        chk("full drops", {31'd0, full}, 32'd0);

        // Age ordering: slot 5 is old, slot 1 is refilled; both wake on tag 13.
        alu_bc(4'd9, 32'd44);
        step(); step();
        put(4'd2, 32'd0, 0, 4'd13, 32'd2, 1, 4'd0, 4'd14);
        step(); step();
        alu_bc(4'd13, 32'd77);
        step(); step();
`ifdef RS_AGE_SELECT_EN
        first_tag = 4'd5; second_tag = 4'd14;
`else
        first_tag = 4'd14; second_tag = 4'd5;
`endif
        chk("order first cal", {31'd0, cal_signal}, 32'd1);
        chk("order first tag", {28'd0, tag}, {28'd0, first_tag});
        chk("order first lhs", lhs, 32'd77);
        rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            put(4'd4, 32'd9, 1, 4'd0, 32'd9, 1, 4'd0, 4'd15);
            alu_bc(4'd8, 32'd99);
            step();
            chk("pause cal", {31'd0, cal_signal}, 32'd1);
            chk("pause tag", {28'd0, tag}, {28'd0, first_tag});
        end
        rdy_in = 1;
        step();
        chk("order second tag", {28'd0, tag}, {28'd0, second_tag});
        step();

        // Refill to full, flush, then broadcasts must not dispatch anything.
        for (int i = 0; i < 3; i++) begin
            put(4'd6, 32'd0, 0, 4'd8, 32'd0, 1, 4'd0, 4'd1);
            step();
        end
        chk("refill full", {31'd0, full}, 32'd1);
        flush = 1;
        step();
        chk("flush full", {31'd0, full}, 32'd0);
        chk("flush cal", {31'd0, cal_signal}, 32'd0);
        for (int t = 8; t < 16; t++) begin
            alu_bc(4'(t), 32'd5);
            step(); step();
            chk("post flush idle", {31'd0, cal_signal}, 32'd0);
        end

        // Randomized traffic; issues only when the model has a free slot.
        for (int c = 0; c < 3000; c++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 149) == 0);
            if (m_count() < 8 && $urandom_range(0, 1) == 1) begin
                put(4'($urandom_range(1, 15)), $urandom, bit'($urandom_range(0, 1)), 4'($urandom),
                    $urandom, bit'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
            end
            alu_done = ($urandom_range(0, 2) == 0);
            alu_tag = 4'($urandom); alu_result = $urandom;
            lsb_done = ($urandom_range(0, 2) == 0);
            lsb_tag = 4'($urandom); lsb_result = $urandom;
            if (lsb_tag == alu_tag) lsb_tag = lsb_tag ^ 4'd1;
            step();
        end
        rdy_in = 1;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
